// File: rtl/fixed_round_sat_pipe.sv
// fixed_round_sat_pipe: two-stage valid/ready requantiser, round-half-up then saturate,
// with a sticky counter of output beats that contained a saturated lane.
module fixed_round_sat_pipe #(
    parameter int DATA_IN_0_PRECISION_0        = 16,
    parameter int DATA_IN_0_PRECISION_1        = 8,
    parameter int DATA_IN_0_PARALLELISM_DIM_0  = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1  = 1,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 4,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
    parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1,
    parameter int SAT_COUNT_WIDTH              = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] i_data_in_0,
    input  logic i_data_in_0_valid,
    output logic o_data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] o_data_out_0,
    output logic o_data_out_0_valid,
    input  logic i_data_out_0_ready,
    input  logic i_sat_clear,
    output logic [SAT_COUNT_WIDTH-1:0] o_sat_count
);
    localparam int IW  = DATA_IN_0_PRECISION_0;
    localparam int IFB = DATA_IN_0_PRECISION_1;
    localparam int OW  = DATA_OUT_0_PRECISION_0;
    localparam int OFB = DATA_OUT_0_PRECISION_1;
    localparam int P   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int SH  = IFB - OFB;
    localparam logic signed [IW:0] RND  = (IW+1)'(SH > 0 ? 1 << (SH > 0 ? SH - 1 : 0) : 0);
    localparam logic signed [IW:0] MAXV = (IW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [IW:0] MINV = -MAXV - 1;

    if (IFB < OFB) begin : g_bad_frac
        $error("output fractional bits exceed input fractional bits");
    end
    if (OW > IW) begin : g_bad_width
        $error("output width exceeds input width");
    end
    if (DATA_OUT_0_PARALLELISM_DIM_0 * DATA_OUT_0_PARALLELISM_DIM_1 != P) begin : g_bad_par
        $error("output parallelism differs from input parallelism");
    end

    logic [P-1:0][IW:0]   w_sum;
    logic [P-1:0][IW:0]   w_r;
    logic [P-1:0][IW:0]   r_s1;
    logic [P-1:0][OW-1:0] w_q;
    logic [P-1:0]         w_sat;
    logic [OW*P-1:0]      r_data_out;
    logic [SAT_COUNT_WIDTH-1:0] r_sat_count;
    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;
    logic w_fire;

    // One extra bit keeps the rounding add from overflowing before the shift.
    for (genvar g = 0; g < P; g++) begin : g_lane
        assign w_sum[g] = $signed({i_data_in_0[g*IW+IW-1], i_data_in_0[g*IW +: IW]}) + RND;
        assign w_r[g]   = $signed(w_sum[g]) >>> SH;
        assign w_sat[g] = ($signed(r_s1[g]) > MAXV) || ($signed(r_s1[g]) < MINV);
        assign w_q[g]   = ($signed(r_s1[g]) > MAXV) ? MAXV[OW-1:0] :
                          ($signed(r_s1[g]) < MINV) ? MINV[OW-1:0] : r_s1[g][OW-1:0];
    end

    assign w_adv2             = r_v1 & (~r_v2 | i_data_out_0_ready);
    assign w_adv1             = ~r_v1 | w_adv2;
    assign w_fire             = i_data_in_0_valid & w_adv1;
    assign o_data_in_0_ready  = rst_n & w_adv1;
    assign o_data_out_0       = r_data_out;
    assign o_data_out_0_valid = r_v2;
    assign o_sat_count        = r_sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_s1        <= '0;
            r_data_out  <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_adv1) r_v1 <= i_data_in_0_valid;
            if (w_adv2) r_v2 <= 1'b1;
            else if (i_data_out_0_ready) r_v2 <= 1'b0;
            if (w_fire) r_s1 <= w_r;
            if (w_adv2) r_data_out <= w_q;
            r_sat_count <= i_sat_clear ? '0 :
                           (w_adv2 && |w_sat && !(&r_sat_count)) ? r_sat_count + 1'b1 : r_sat_count;
        end
    end
endmodule

// File: tb/tb_fixed_round_sat_pipe.sv
// tb_fixed_round_sat_pipe: random and directed streams checked against an arithmetic
// model of round-half-up plus saturation, with occupancy-based ready and hold checks.
module tb_fixed_round_sat_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_out_ready;
    logic        i_sat_clear;
    logic [15:0] o_sat_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int mode = 0;
    int n_out = 0;
    int last_cyc = 0;
    int m_cnt = 0;
    logic [32:0] q[$];
    logic        p_valid = 0, p_fire = 0, p_stall = 0, p_clear = 0;
    logic [31:0] p_data = 0;

    fixed_round_sat_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .i_data_in_0(i_data), .i_data_in_0_valid(i_valid), .o_data_in_0_ready(o_ready),
        .o_data_out_0(o_data), .o_data_out_0_valid(o_valid), .i_data_out_0_ready(i_out_ready),
        .i_sat_clear(i_sat_clear), .o_sat_count(o_sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        i_out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~i_out_ready :
                      (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected beat: {saturated flag, four 8-bit lanes}, from floor((x + 8) / 16) then clamp.
    function automatic logic [32:0] model(input logic [63:0] x);
        logic [32:0] res = '0;
        for (int i = 0; i < 4; i++) begin
            int v, num, r;
            v   = int'($signed(x[16*i +: 16]));
            num = v + 8;
            r   = (num >= 0) ? num / 16 : -((-num + 15) / 16);
            if (r > 127) begin r = 127; res[32] = 1'b1; end
            else if (r < -128) begin r = -128; res[32] = 1'b1; end
            res[8*i +: 8] = r[7:0];
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 64'(o_valid), 64'd0);
            check("rst_data", 64'(o_data), 64'd0);
            check("rst_count", 64'(o_sat_count), 64'd0);
            check("rst_ready", 64'(o_ready), 64'd0);
            q.delete();
            m_cnt = 0;
            p_valid = 0; p_fire = 0; p_stall = 0; p_clear = 0;
        end else begin
            logic new_beat;
            logic [32:0] e;
            new_beat = o_valid && (!p_valid || p_fire);
            if (p_clear) m_cnt = 0;
            if (p_stall) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_data", 64'(o_data), 64'(p_data));
            end
            if (new_beat) begin
                if (q.size() == 0) check("unexpected_beat", 64'(o_data), 64'hdead);
                else begin
                    e = q.pop_front();
                    check("beat_data", 64'(o_data), 64'(e[31:0]));
                    if (!p_clear && e[32] && m_cnt != 65535) m_cnt++;
                    n_out++;
                    last_cyc = cyc;
                end
            end
            check("sat_count", 64'(o_sat_count), 64'(m_cnt));
            check("in_ready", 64'(o_ready), 64'(!(q.size() != 0 && o_valid && !i_out_ready)));
            if (i_valid && o_ready) q.push_back(model(i_data));
            p_valid = o_valid;
            p_fire  = o_valid & i_out_ready;
            p_stall = o_valid & ~i_out_ready;
            p_data  = o_data;
            p_clear = i_sat_clear;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the beat was accepted.
    task automatic send(input logic [63:0] d);
        i_valid = 1'b1;
        i_data  = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (o_ready) break;
            if (n > 200) begin check("send_timeout", 64'd0, 64'd1); break; end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !o_valid) break;
            if (n > 300) begin check("drain_timeout", 64'(q.size()), 64'd0); break; end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_beat();
        logic [63:0] d;
        for (int i = 0; i < 4; i++)
            d[16*i +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4200) - 2100);
        return d;
    endfunction

    initial begin
        int c0, o0;
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_sat_clear = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // rounding
        send(64'hFFF8_0008_FFE8_0018);
        @(negedge clk); @(negedge clk);
        check("t1_data", 64'(o_data), 64'h0001_FF02);
        check("t1_count", 64'(o_sat_count), 64'd0);
        // saturation
        @(posedge clk); #1;
        send(64'hF800_07F7_F060_0FA0);
        @(negedge clk); @(negedge clk);
        check("t2_data", 64'(o_data), 64'h807F_807F);
        check("t2_count", 64'(o_sat_count), 64'd1);
        @(posedge clk); #1;
        send(64'h0);
        @(negedge clk); @(negedge clk);
        check("t2_zero", 64'(o_data), 64'h0);
        check("t2_count_hold", 64'(o_sat_count), 64'd1);
        drain();
        // back-pressure with alternating downstream ready
        mode = 1;
        o0 = n_out;
        for (int k = 1; k <= 8; k++) send({16'(16*k), 16'(16*k), 16'(16*k), 16'(16*k)});
        drain();
        check("t3_beats", 64'(n_out - o0), 64'd8);
        // throughput
        mode = 0;
        @(posedge clk); #1;
        c0 = cyc; o0 = n_out;
        for (int k = 0; k < 100; k++) send(64'($urandom_range(0, 1000)));
        drain();
        check("t4_beats", 64'(n_out - o0), 64'd100);
        check("t4_span", 64'(last_cyc - c0), 64'd101);
        // random traffic
        mode = 2;
        for (int k = 0; k < 1500; k++) begin
            i_sat_clear = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            else send(rand_beat());
        end
        i_sat_clear = 1'b0;
        drain();
        // counter saturation, then clear together with a saturating beat
        mode = 0;
        for (int k = 0; k < 70000; k++) send(64'h0FA0_0FA0_0FA0_0FA0);
        drain();
        check("t5_sticky", 64'(o_sat_count), 64'd65535);
        send(64'h0FA0_0FA0_0FA0_0FA0);
        i_sat_clear = 1'b1;
        @(posedge clk); #1;
        i_sat_clear = 1'b0;
        @(negedge clk);
        check("t5_clear_wins", 64'(o_sat_count), 64'd0);
        drain();
        // reset with both stages full
        mode = 3;
        send(64'hF060_F060_F060_F060);
        send(64'h0FA0_0FA0_0FA0_0FA0);
        @(negedge clk);
        check("t6_full_ready", 64'(o_ready), 64'd0);
        check("t6_full_count", 64'(o_sat_count), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(o_valid), 64'd0);
        check("t6_async_data", 64'(o_data), 64'd0);
        check("t6_async_count", 64'(o_sat_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 0;
        send(64'h0010_0010_0010_0010);
        @(negedge clk); @(negedge clk);
        check("t6_after", 64'(o_data), 64'h0101_0101);
        drain();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
